// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, state type and op-class helpers for the multiply/divide unit
//
// Purpose: op-code constants (md_op_t), busy FSM state type and small
// helpers that classify an op as multiply, divide or move-to-HI/LO.
// Ports: none (package).
// Configuration macro consumed elsewhere: MD_DIV_ZERO_KEEP_EN.
package md_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t OP_MULT  = 3'd0;
  localparam md_op_t OP_MULTU = 3'd1;
  localparam md_op_t OP_DIV   = 3'd2;
  localparam md_op_t OP_DIVU  = 3'd3;
  localparam md_op_t OP_MTHI  = 3'd4;
  localparam md_op_t OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_mul(input md_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mt(input md_op_t op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath
//
// Purpose: computes the HI/LO pair for MULT/MULTU/DIV/DIVU in one
// combinational pass; the owning unit only stages and delays the result.
// Ports:
//   A        in  WIDTH  dividend / multiplicand
//   B        in  WIDTH  divisor / multiplier
//   md_op    in  3      op code (md_pkg)
//   res_hi   out WIDTH  product upper half / remainder
//   res_lo   out WIDTH  product lower half / quotient
//   div_zero out 1      divide op with B == 0 (results are don't-care then)
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  md_op_t           md_op,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quot_m;
  logic [WIDTH-1:0]   rem_m;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   rem_u;

  // Sign-extend to full width so the low 2*WIDTH bits of an unsigned
  // multiply equal the two's-complement signed product.
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign a_neg  = A[WIDTH-1];
  assign b_neg  = B[WIDTH-1];
  assign b_zero = (B == '0);
  // Keep the divider away from a zero divisor; the unit substitutes its own
  // divide-by-zero policy.
  assign div_b  = b_zero ? ONE : B;

  // Signed divide on magnitudes. MIN_INT's magnitude is representable as an
  // unsigned value, so MIN_INT / -1 naturally yields MIN_INT with remainder 0.
  assign mag_a  = a_neg ? (~A + ONE) : A;
  assign mag_b  = b_neg ? (~B + ONE) : div_b;
  assign quot_m = mag_a / mag_b;
  assign rem_m  = mag_a % mag_b;
  assign quot_s = (a_neg ^ b_neg) ? (~quot_m + ONE) : quot_m;
  assign rem_s  = a_neg ? (~rem_m + ONE) : rem_m;

  assign quot_u = A / div_b;
  assign rem_u  = A % div_b;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo   = quot_s;
        res_hi   = rem_s;
        div_zero = b_zero;
      end
      OP_DIVU: begin
        res_lo   = quot_u;
        res_hi   = rem_u;
        div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: accepts one op per start pulse while idle, computes the result
// immediately into staging registers, and exposes it on hi/lo only after a
// fixed per-op busy window. MTHI/MTLO write hi/lo directly.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-high reset
//   start  in  1      op request, sampled at posedge clk
//   md_op  in  3      op code (md_pkg); 6/7 are no-ops
//   A      in  WIDTH  operand rs
//   B      in  WIDTH  operand rt
//   busy   out 1      op in flight
//   hi     out WIDTH  HI register
//   lo     out WIDTH  LO register
// Macro: MD_DIV_ZERO_KEEP_EN - divide by zero leaves hi/lo unchanged;
//   otherwise divide by zero yields lo = all-ones, hi = dividend.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_n;
  logic             load;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;
  logic [WIDTH-1:0] stage_hi;
  logic [WIDTH-1:0] stage_lo;
`ifdef MD_DIV_ZERO_KEEP_EN
  logic             stage_keep;
`endif

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .A        (A),
    .B        (B),
    .md_op    (md_op),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign load_n = is_mul(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
  assign busy   = (state == S_BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Any start seen in S_BUSY falls through with no effect.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    commit     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_mul(md_op) || is_div(md_op)) begin
            load       = 1'b1;
            state_next = S_BUSY;
          end else if (is_mt(md_op)) begin
            wr_hi = (md_op == OP_MTHI);
            wr_lo = (md_op == OP_MTLO);
          end
        end
      end
      S_BUSY: begin
        // count holds the number of edges left; the last one commits.
        if (count == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 count <= '0;
    else if (load)             count <= load_n;
    else if (state == S_BUSY)  count <= count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_hi   <= '0;
      stage_lo   <= '0;
`ifdef MD_DIV_ZERO_KEEP_EN
      stage_keep <= 1'b0;
`endif
    end else if (load) begin
`ifdef MD_DIV_ZERO_KEEP_EN
      stage_hi   <= res_hi;
      stage_lo   <= res_lo;
      stage_keep <= div_zero;
`else
      stage_hi   <= div_zero ? A  : res_hi;
      stage_lo   <= div_zero ? '1 : res_lo;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
`ifdef MD_DIV_ZERO_KEEP_EN
      if (commit && !stage_keep) begin
`else
      if (commit) begin
`endif
        hi <= stage_hi;
        lo <= stage_lo;
      end
      if (wr_hi) hi <= A;
      if (wr_lo) lo <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit with a behavioural HI/LO model
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural model: updates exp_hi/exp_lo to the post-op values and
  // returns the busy latency (0 for ops that never raise busy).
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0]        p;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    n  = 0;
    case (op)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; n = MC; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; n = MC; end
      3'd2, 3'd3: begin
        n = DC;
        if (b == 32'h0) begin
`ifndef MD_DIV_ZERO_KEEP_EN
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = a;
`endif
        end else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issues one op at a negedge and follows it until the result is visible.
  // inject pulses a stray start in the middle of the busy window.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model(op, a, b, n);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    md_op = 3'($urandom_range(0, 7));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("busy_during_op", {31'b0, busy}, 32'd1);
      check("hi_held", hi, old_hi);
      check("lo_held", lo, old_lo);
      start = inject && (k == 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("busy_after_op", {31'b0, busy}, 32'd0);
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd0;
    A        = '0;
    B        = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd7, 32'd2, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'h0000_0055, 32'd0, 1'b0);
    run_op(3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(3'd4, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd5, 32'h0000_5678, 32'd0, 1'b0);
    run_op(3'd6, 32'hAAAA_AAAA, 32'd5, 1'b0);
    run_op(3'd7, 32'h5555_5555, 32'd5, 1'b0);

    // Stray starts during busy must not disturb the result or latency.
    run_op(3'd0, 32'h0001_0003, 32'h0002_0007, 1'b1);
    run_op(3'd3, 32'hFFFF_0000, 32'd9, 1'b1);

    // Back-to-back: DIVU starts the cycle right after the MULT commit.
    run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op(3'd3, 32'd1000, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      op = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(op, ra, rb, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a DIV: everything clears at once and the
    // discarded result never appears after release.
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    run_op(3'd4, 32'hBEEF_0001, 32'd0, 1'b0);
    start = 1'b1;
    md_op = 3'd2;
    A     = 32'd100;
    B     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    for (int k = 0; k < DC + 2; k++) begin
      @(negedge clk);
      check("post_reset_busy", {31'b0, busy}, 32'd0);
      check("post_reset_hi", hi, exp_hi);
      check("post_reset_lo", lo, exp_lo);
    end

    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
